// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for one synchronous port of the CR16 memory.
// Supports a bounded ownership lock so one master can issue back-to-back bursts.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                 state;
  logic                   prio;
  logic [CNT_W-1:0]       burst_cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   gnt0;
  logic                   gnt1;

  // Grant selection: round-robin in IDLE, owner-only while locked; nothing in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          gnt0 = req0 & (~req1 | ~prio);
          gnt1 = req1 & (~req0 | prio);
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  // Accept and memory port mux; address holds its last value when nobody is granted.
  always_comb begin
    ack0        = gnt0;
    ack1        = gnt1;
    mem_wr_en   = (gnt0 & we0) | (gnt1 & we1);
    mem_wr_data = gnt1 ? wdata1 : wdata0;
    if (gnt0)      mem_addr = addr0;
    else if (gnt1) mem_addr = addr1;
    else           mem_addr = addr_q;
    rdata0      = rvalid0 ? mem_rd_data : '0;
    rdata1      = rvalid1 ? mem_rd_data : '0;
  end

  // Burst count after this access: restarts at 1 when taken from IDLE.
  always_comb begin
    cnt_inc = (state == IDLE) ? CNT_W'(1) : burst_cnt + CNT_W'(1);
  end

  // Ownership state machine, priority, burst counter and read-return flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      burst_cnt <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      addr_q    <= '0;
    end else begin
      rvalid0 <= ack0 & ~we0;
      rvalid1 <= ack1 & ~we1;
      if (ack0 | ack1) addr_q <= mem_addr;

      if (ack0) begin
        if (lock0 && (cnt_inc < CNT_W'(MAX_BURST))) begin
          state     <= OWN0;
          burst_cnt <= cnt_inc;
        end else begin
          state     <= IDLE;
          burst_cnt <= '0;
          prio      <= 1'b1;
        end
      end else if (ack1) begin
        if (lock1 && (cnt_inc < CNT_W'(MAX_BURST))) begin
          state     <= OWN1;
          burst_cnt <= cnt_inc;
        end else begin
          state     <= IDLE;
          burst_cnt <= '0;
          prio      <= 1'b0;
        end
      end else if ((state == OWN0) && !req0) begin
        state     <= IDLE;
        burst_cnt <= '0;
        prio      <= 1'b1;
      end else if ((state == OWN1) && !req1) begin
        state     <= IDLE;
        burst_cnt <= '0;
        prio      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a synchronous memory model
// and a read-return scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          reset_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  logic          mem_init;
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rd_t;
  rd_t sb[$];

  int n_tests;
  int n_fail;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 16'h1234 : DW'(i * 37 + 16'h0100);
  endfunction

  // Synchronous memory: write on posedge, read data one cycle after address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: check returns, then expected acks; record expected read data.
  task automatic step(input logic e0, input logic e1);
    logic xr0, xr1;
    @(negedge clk);
    xr0 = (sb.size() > 0) && (sb[0].port == 1'b0);
    xr1 = (sb.size() > 0) && (sb[0].port == 1'b1);
    chk("rvalid0", 32'(rvalid0), 32'(xr0));
    chk("rvalid1", 32'(rvalid1), 32'(xr1));
    if (xr0) chk("rdata0", 32'(rdata0), 32'(sb[0].data));
    else     chk("rdata0_zero", 32'(rdata0), 32'(0));
    if (xr1) chk("rdata1", 32'(rdata1), 32'(sb[0].data));
    else     chk("rdata1_zero", 32'(rdata1), 32'(0));
    if (xr0 || xr1) void'(sb.pop_front());
    chk("ack0", 32'(ack0), 32'(e0));
    chk("ack1", 32'(ack1), 32'(e1));
    chk("mem_wr_en", 32'(mem_wr_en), 32'((e0 & we0) | (e1 & we1)));
    if (e0) begin
      chk("mem_addr0", 32'(mem_addr), 32'(addr0));
      if (we0) ref_mem[addr0] = wdata0;
      else     sb.push_back('{port: 1'b0, data: ref_mem[addr0]});
    end
    if (e1) begin
      chk("mem_addr1", 32'(mem_addr), 32'(addr1));
      if (we1) ref_mem[addr1] = wdata1;
      else     sb.push_back('{port: 1'b1, data: ref_mem[addr1]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step(1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    idle_inputs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset_n  = 1'b0;
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    mem_init = 1'b0;

    // Reset: requests (including a write) are ignored while reset_n is low.
    req0 = 1'b1; we0 = 1'b1; req1 = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    idle_inputs();
    reset_n = 1'b1;

    // Single read of address 5.
    req0 = 1'b1; addr0 = AW'(5);
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b0);
    chk("rdata_after_idle", 32'(rdata0), 32'(0));

    // Alternation with both requesting, no locks.
    do_reset();
    req0 = 1'b1; addr0 = AW'(10);
    req1 = 1'b1; addr1 = AW'(20);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
    end
    idle_inputs();
    step(1'b0, 1'b0);

    // Burst limit: four locked accesses, then forced release.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; addr0 = AW'(30);
    req1 = 1'b1; addr1 = AW'(40);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle_inputs();
    step(1'b0, 1'b0);

    // Write/read collision on address 7 serialized, read sees new data.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(7); wdata0 = 16'hBEEF;
    req1 = 1'b1; addr1 = AW'(7);
    step(1'b1, 1'b0);
    req0 = 1'b0; we0 = 1'b0;
    step(1'b0, 1'b1);
    req1 = 1'b0;
    step(1'b0, 1'b0);
    chk("beef_ref", 32'(ref_mem[7]), 32'(16'hBEEF));

    // Lock dropped on the second burst access hands over to master 1.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; addr0 = AW'(11);
    req1 = 1'b1; addr1 = AW'(12);
    step(1'b1, 1'b0);
    lock0 = 1'b0;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b1);
    idle_inputs();
    step(1'b0, 1'b0);

    // Owner drops req while locked: release cycle without ack, then master 1.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; addr0 = AW'(13);
    req1 = 1'b1; addr1 = AW'(14);
    step(1'b1, 1'b0);
    req0 = 1'b0; lock0 = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle_inputs();
    step(1'b0, 1'b0);

    // Reset during OWN0 with a read pending; afterwards IDLE with prio 0.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; addr0 = AW'(50);
    req1 = 1'b1; addr1 = AW'(51);
    step(1'b1, 1'b0);
    reset_n = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset_n = 1'b1;
    lock0 = 1'b0;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b1);
    idle_inputs();
    step(1'b0, 1'b0);

    // Master 1 write then master 0 read; address holds while idle.
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = AW'(9); wdata1 = 16'hCAFE;
    step(1'b0, 1'b1);
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; addr0 = AW'(9);
    step(1'b1, 1'b0);
    req0 = 1'b0; addr0 = AW'(100); addr1 = AW'(200);
    step(1'b0, 1'b0);
    chk("mem_addr_hold", 32'(mem_addr), 32'(9));
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
